timer_param_bank: RTL and testbench



---
 rtl/tpb_pkg.sv | 13 +
 rtl/tpb_countdown.sv | 70 +++++++
 rtl/timer_param_bank.sv | 116 +++++++++++
 tb/tb_timer_param_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpb_pkg.sv
// Shared types and constants for the timer parameter bank.
// Index 3..0 resets to 10, 8, 15, 6, so the packed constant reads 16'hA8F6.
package tpb_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE   = 2'd0,
        TMR_RUN    = 2'd1,
        TMR_EXPIRE = 2'd2
    } tmr_state_e;

    localparam logic [15:0] TPB_DEFAULTS = {4'd10, 4'd8, 4'd15, 4'd6};

endpackage

// File: rtl/tpb_countdown.sv
// Countdown FSM: loads a duration, decrements on each tick while running and
// spends exactly one cycle in EXPIRE before returning to IDLE.
module tpb_countdown
    import tpb_pkg::*;
#(
    parameter int VAL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [VAL_W-1:0] load_value,
    input  logic             abort,
    input  logic             tick,
    output logic             busy,
    output logic [VAL_W-1:0] remaining,
    output logic             expired
);

    tmr_state_e       state_reg, state_next;
    logic [VAL_W-1:0] remaining_reg, remaining_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= TMR_IDLE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    // Abort outranks a load; a load outranks the per-state behaviour.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        if (abort) begin
            state_next     = TMR_IDLE;
            remaining_next = '0;
        end else if (load) begin
            state_next     = TMR_RUN;
            remaining_next = load_value;
        end else begin
            case (state_reg)
                TMR_RUN: begin
                    if (tick) begin
                        if (remaining_reg == VAL_W'(1)) begin
                            state_next     = TMR_EXPIRE;
                            remaining_next = '0;
                        end else begin
                            remaining_next = remaining_reg - VAL_W'(1);
                        end
                    end
                end
                TMR_EXPIRE: begin
                    state_next     = TMR_IDLE;
                    remaining_next = '0;
                end
                default: begin
                    state_next     = TMR_IDLE;
                    remaining_next = '0;
                end
            endcase
        end
    end

    assign busy      = (state_reg == TMR_RUN);
    assign expired   = (state_reg == TMR_EXPIRE);
    assign remaining = remaining_reg;

endmodule

// File: rtl/timer_param_bank.sv
// Bank of writable timing parameters driving one countdown timer.
// Optional macro TPB_LOCK_EN adds a sticky write lock (lock_req port).
module timer_param_bank
    import tpb_pkg::*;
#(
    parameter  int                          NUM_PARAMS = 4,
    parameter  int                          VAL_W      = 4,
    parameter  logic [NUM_PARAMS*VAL_W-1:0] DEFAULTS   = TPB_DEFAULTS,
    localparam int                          SEL_W      = (NUM_PARAMS > 2) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [SEL_W-1:0]            wr_sel,
    input  logic [VAL_W-1:0]            wr_value,
    output logic                        wr_err,
    output logic [NUM_PARAMS*VAL_W-1:0] param_out,
    input  logic                        tmr_start,
    input  logic                        tmr_abort,
    input  logic [SEL_W-1:0]            tmr_sel,
    input  logic                        tick_1hz,
    output logic                        tmr_busy,
    output logic [VAL_W-1:0]            tmr_remaining,
    output logic                        tmr_expired
`ifdef TPB_LOCK_EN
    ,
    input  logic                        lock_req
`endif
);

    localparam int SEL_SPAN = 2 ** SEL_W;

    logic [SEL_SPAN-1:0]            sel_ok_map;
    logic [SEL_SPAN-1:0][VAL_W-1:0] param_pad;
    logic [SEL_W-1:0]               active_sel_reg;
    logic                           wr_err_reg;
    logic                           wr_fire, wr_bad, wr_commit;
    logic                           tmr_load;
    logic                           locked;

`ifdef TPB_LOCK_EN
    logic lock_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_reg <= 1'b0;
        end else if (lock_req) begin
            lock_reg <= 1'b1;
        end
    end

    assign locked = lock_reg;
`else
    assign locked = 1'b0;
`endif

    // Only the parameter feeding the running countdown is write-protected.
    assign wr_ready  = !(tmr_busy && (wr_sel == active_sel_reg));
    assign wr_fire   = wr_valid && wr_ready;
    assign wr_bad    = (wr_value == '0) || !sel_ok_map[wr_sel] || locked;
    assign wr_commit = wr_fire && !wr_bad;

    // Selector values past NUM_PARAMS map to an invalid, zero-valued slot.
    for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_slot
        if (gi < NUM_PARAMS) begin : g_param
            logic [VAL_W-1:0] value_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= DEFAULTS[gi*VAL_W +: VAL_W];
                end else if (wr_commit && (wr_sel == SEL_W'(gi))) begin
                    value_reg <= wr_value;
                end
            end

            assign sel_ok_map[gi]                = 1'b1;
            assign param_pad[gi]                 = value_reg;
            assign param_out[gi*VAL_W +: VAL_W]  = value_reg;
        end else begin : g_pad
            assign sel_ok_map[gi] = 1'b0;
            assign param_pad[gi]  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_reg     <= 1'b0;
            active_sel_reg <= '0;
        end else begin
            wr_err_reg <= wr_fire && wr_bad;
            if (tmr_load && !tmr_abort) begin
                active_sel_reg <= tmr_sel;
            end
        end
    end

    assign wr_err   = wr_err_reg;
    assign tmr_load = tmr_start && sel_ok_map[tmr_sel];

    // param_pad holds pre-edge storage, so a same-cycle write never affects the load.
    tpb_countdown #(
        .VAL_W(VAL_W)
    ) u_countdown (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .load_value(param_pad[tmr_sel]),
        .abort     (tmr_abort),
        .tick      (tick_1hz),
        .busy      (tmr_busy),
        .remaining (tmr_remaining),
        .expired   (tmr_expired)
    );

endmodule

// File: tb/tb_timer_param_bank.sv
// Directed, table-driven bench for timer_param_bank (default parameters).
module tb_timer_param_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_sel;
    logic [3:0]  wr_value;
    logic        wr_err;
    logic [15:0] param_out;
    logic        tmr_start;
    logic        tmr_abort;
    logic [1:0]  tmr_sel;
    logic        tick_1hz;
    logic        tmr_busy;
    logic [3:0]  tmr_remaining;
    logic        tmr_expired;
`ifdef TPB_LOCK_EN
    logic        lock_req;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        wv;
        logic [1:0]  ws;
        logic [3:0]  wd;
        logic        st;
        logic        ab;
        logic [1:0]  ts;
        logic        tk;
        logic        rdy;
        logic [15:0] par;
        logic        busy;
        logic [3:0]  rem;
        logic        expd;
        logic        err;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    timer_param_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_sel       (wr_sel),
        .wr_value     (wr_value),
        .wr_err       (wr_err),
        .param_out    (param_out),
        .tmr_start    (tmr_start),
        .tmr_abort    (tmr_abort),
        .tmr_sel      (tmr_sel),
        .tick_1hz     (tick_1hz),
        .tmr_busy     (tmr_busy),
        .tmr_remaining(tmr_remaining),
        .tmr_expired  (tmr_expired)
`ifdef TPB_LOCK_EN
        ,
        .lock_req     (lock_req)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int wv, int ws, int wd, int st, int ab, int ts, int tk,
                                int rdy, int par, int busy, int rem, int expd, int err);
        vec_t v;
        v.wv   = 1'(wv);
        v.ws   = 2'(ws);
        v.wd   = 4'(wd);
        v.st   = 1'(st);
        v.ab   = 1'(ab);
        v.ts   = 2'(ts);
        v.tk   = 1'(tk);
        v.rdy  = 1'(rdy);
        v.par  = 16'(par);
        v.busy = 1'(busy);
        v.rem  = 4'(rem);
        v.expd = 1'(expd);
        v.err  = 1'(err);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive_idle();
        wr_valid  = 1'b0;
        wr_sel    = 2'd0;
        wr_value  = 4'd0;
        tmr_start = 1'b0;
        tmr_abort = 1'b0;
        tmr_sel   = 2'd0;
        tick_1hz  = 1'b0;
`ifdef TPB_LOCK_EN
        lock_req  = 1'b0;
`endif
    endtask

    initial begin
        // wv ws wd st ab ts tk | rdy param busy rem exp err
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA8F6, 0, 0, 0, 0);
        vecs[1]  = mk(1, 2, 3, 0, 0, 0, 0, 1, 'hA3F6, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 2, 0, 1, 'hA3F6, 1, 3, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA3F6, 1, 2, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA3F6, 1, 2, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA3F6, 1, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA3F6, 0, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA3F6, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA3F6, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 'hA3F6, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA3F6, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 0, 0, 1, 'hA3F6, 1, 6, 0, 0);
        vecs[12] = mk(1, 0, 9, 0, 0, 0, 0, 0, 'hA3F6, 1, 6, 0, 0);
        vecs[13] = mk(1, 1, 7, 0, 0, 0, 1, 1, 'hA376, 1, 5, 0, 0);
        vecs[14] = mk(1, 0, 9, 0, 0, 0, 0, 0, 'hA376, 1, 5, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 1, 1, 0, 1, 'hA376, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA376, 0, 0, 0, 0);
        vecs[17] = mk(1, 0, 9, 0, 0, 0, 0, 1, 'hA379, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 0, 3, 0, 1, 'hA379, 1, 10, 0, 0);
        vecs[19] = mk(0, 0, 0, 1, 0, 1, 0, 1, 'hA379, 1, 7, 0, 0);
        vecs[20] = mk(1, 2, 5, 1, 0, 2, 0, 1, 'hA579, 1, 3, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA579, 1, 2, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA579, 1, 1, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA579, 0, 0, 1, 0);
        vecs[24] = mk(0, 0, 0, 1, 0, 2, 0, 1, 'hA579, 1, 5, 0, 0);
        vecs[25] = mk(1, 2, 1, 0, 0, 0, 0, 0, 'hA579, 1, 5, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 1, 0, 0, 1, 'hA579, 0, 0, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hA579, 0, 0, 0, 0);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset param_out", 32'(param_out), 32'hA8F6);
        chk("reset busy", 32'(tmr_busy), 32'd0);
        chk("reset remaining", 32'(tmr_remaining), 32'd0);
        chk("reset wr_err", 32'(wr_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wr_valid  = vecs[i].wv;
            wr_sel    = vecs[i].ws;
            wr_value  = vecs[i].wd;
            tmr_start = vecs[i].st;
            tmr_abort = vecs[i].ab;
            tmr_sel   = vecs[i].ts;
            tick_1hz  = vecs[i].tk;
            #1;
            if (vecs[i].wv) chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d param_out", i), 32'(param_out), 32'(vecs[i].par));
            chk($sformatf("v%0d busy", i), 32'(tmr_busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d remaining", i), 32'(tmr_remaining), 32'(vecs[i].rem));
            chk($sformatf("v%0d expired", i), 32'(tmr_expired), 32'(vecs[i].expd));
            chk($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(vecs[i].err));
            $display("vec %0d: param=%h busy=%0d rem=%0d exp=%0d err=%0d",
                     i, param_out, tmr_busy, tmr_remaining, tmr_expired, wr_err);
        end

        // Asynchronous reset in the middle of a countdown.
        @(negedge clk);
        drive_idle();
        tmr_start = 1'b1;
        tmr_sel   = 2'd3;
        @(posedge clk);
        #1;
        chk("rstmid start rem", 32'(tmr_remaining), 32'd10);
        @(negedge clk);
        drive_idle();
        tick_1hz = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid tick rem", 32'(tmr_remaining), 32'd9);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("rstmid busy async", 32'(tmr_busy), 32'd0);
        chk("rstmid rem async", 32'(tmr_remaining), 32'd0);
        chk("rstmid param async", 32'(param_out), 32'hA8F6);
        chk("rstmid expired async", 32'(tmr_expired), 32'd0);
        @(posedge clk);
        #1;
        chk("rstmid expired held", 32'(tmr_expired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid busy after", 32'(tmr_busy), 32'd0);
        chk("rstmid expired after", 32'(tmr_expired), 32'd0);
        $display("reset mid-count: busy=%0d rem=%0d", tmr_busy, tmr_remaining);

`ifdef TPB_LOCK_EN
        @(negedge clk);
        drive_idle();
        lock_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        wr_valid = 1'b1;
        wr_sel   = 2'd3;
        wr_value = 4'd5;
        @(posedge clk);
        #1;
        chk("lock param kept", 32'(param_out), 32'hA8F6);
        chk("lock wr_err", 32'(wr_err), 32'd1);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        chk("lock wr_err clears", 32'(wr_err), 32'd0);
        $display("locked write: param=%h", param_out);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
